// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Memory-stage access controller between the MIPS32 pipeline and the
//   word-addressed data memory (words 1024..2047). Byte-addressed loads and
//   stores (LW/LH/LHU/LB/LBU/SW/SH/SB) are turned into whole-word accesses.
//   Loads are sign- or zero-extended. Sub-word stores use a read-modify-write
//   sequence. Misaligned and out-of-range addresses complete at once with err.
//   Byte order is big-endian: byte offset 0 is bits [31:24].
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_req          request strobe, sampled only while idle
//   i_memOp        0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
//   i_addr         byte address
//   i_wdata        store data (SH uses [15:0], SB uses [7:0])
//   o_busy         high in every state except IDLE
//   o_done         one-cycle completion pulse
//   o_err          valid with o_done; misaligned or out-of-range address
//   o_rdata        extended load result, held between loads
//   o_dmAddr       word address to data memory (latched addr[12:2])
//   o_dmWriteData  word written to data memory
//   o_dmMemWrite   data memory write enable
//   o_dmMemRead    data memory read enable
//   i_dmReadData   combinational data memory read port
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter logic [31:0] BASE_BYTE  = 32'h0000_1000,
    parameter logic [31:0] LIMIT_BYTE = 32'h0000_1FFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [2:0]  i_memOp,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [10:0] o_dmAddr,
    output logic [31:0] o_dmWriteData,
    output logic        o_dmMemWrite,
    output logic        o_dmMemRead,
    input  logic [31:0] i_dmReadData
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_MERGE_WR = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_memOp;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;
    logic [31:0] r_merge;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [10:0] r_dmAddr;
    logic [31:0] r_dmWriteData;
    logic        r_dmMemWrite;
    logic        r_dmMemRead;

    logic        w_inRange;
    logic        w_misaligned;
    logic        w_legal;
    logic        w_isLoad;
    logic        w_isSubStore;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_loadData;
    logic [31:0] w_mergedWord;

    // Legality of the incoming request, judged on the live inputs in IDLE.
    always_comb begin
        w_inRange    = (i_addr >= BASE_BYTE) && (i_addr <= LIMIT_BYTE);
        w_misaligned = 1'b0;
        case (i_memOp)
            OP_LW, OP_SW:         w_misaligned = (i_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_misaligned = i_addr[0];
            default:              w_misaligned = 1'b0;
        endcase
        w_legal = w_inRange && !w_misaligned;
    end

    // Operation class of the latched request.
    always_comb begin
        w_isLoad     = (r_memOp <= OP_LBU);
        w_isSubStore = (r_memOp == OP_SH) || (r_memOp == OP_SB);
    end

    // Lane selection and extension of the word read in ACCESS (big-endian).
    always_comb begin
        w_half = r_offset[1] ? i_dmReadData[15:0] : i_dmReadData[31:16];
        case (r_offset)
            2'd0:    w_byte = i_dmReadData[31:24];
            2'd1:    w_byte = i_dmReadData[23:16];
            2'd2:    w_byte = i_dmReadData[15:8];
            default: w_byte = i_dmReadData[7:0];
        endcase
        case (r_memOp)
            OP_LH:   w_loadData = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_loadData = {16'h0000, w_half};
            OP_LB:   w_loadData = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_loadData = {24'h00_0000, w_byte};
            default: w_loadData = i_dmReadData;
        endcase
    end

    // Merge register with the target lane replaced by the store data.
    always_comb begin
        w_mergedWord = r_merge;
        if (r_memOp == OP_SH) begin
            if (r_offset[1]) begin
                w_mergedWord[15:0] = r_wdata;
            end else begin
                w_mergedWord[31:16] = r_wdata;
            end
        end else begin
            case (r_offset)
                2'd0:    w_mergedWord[31:24] = r_wdata[7:0];
                2'd1:    w_mergedWord[23:16] = r_wdata[7:0];
                2'd2:    w_mergedWord[15:8]  = r_wdata[7:0];
                default: w_mergedWord[7:0]   = r_wdata[7:0];
            endcase
        end
    end

    // Control FSM. All pipeline-facing and memory-facing strobes are
    // registered here, so req never reaches a dm* output combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_memOp       <= OP_LW;
            r_offset      <= 2'd0;
            r_wdata       <= 16'h0000;
            r_merge       <= 32'h0000_0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= 32'h0000_0000;
            r_dmAddr      <= 11'd0;
            r_dmWriteData <= 32'h0000_0000;
            r_dmMemWrite  <= 1'b0;
            r_dmMemRead   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (i_req) begin
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_state  <= S_ACCESS;
                            r_memOp  <= i_memOp;
                            r_offset <= i_addr[1:0];
                            r_wdata  <= i_wdata[15:0];
                            r_dmAddr <= i_addr[12:2];
                            if (i_memOp == OP_SW) begin
                                r_dmMemWrite  <= 1'b1;
                                r_dmWriteData <= i_wdata;
                            end else begin
                                // Loads and the read half of SH/SB.
                                r_dmMemRead <= 1'b1;
                            end
                        end else begin
                            // Illegal request: finish immediately, no strobe.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end

                S_ACCESS: begin
                    r_dmMemRead  <= 1'b0;
                    r_dmMemWrite <= 1'b0;
                    if (w_isSubStore) begin
                        r_merge      <= i_dmReadData;
                        r_dmMemWrite <= 1'b1;
                        r_state      <= S_MERGE_WR;
                    end else begin
                        if (w_isLoad) begin
                            r_rdata <= w_loadData;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_MERGE_WR: begin
                    // Keep the written word visible after the write completes.
                    r_dmMemWrite  <= 1'b0;
                    r_dmWriteData <= w_mergedWord;
                    r_done        <= 1'b1;
                    r_state       <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During MERGE_WR the written word comes straight from the merge
    // register; the write enable is masked by reset so an abandoned access
    // never reaches memory.
    always_comb begin
        o_busy        = r_busy;
        o_done        = r_done;
        o_err         = r_err;
        o_rdata       = r_rdata;
        o_dmAddr      = r_dmAddr;
        o_dmWriteData = (r_state == S_MERGE_WR) ? w_mergedWord : r_dmWriteData;
        o_dmMemWrite  = r_dmMemWrite && i_rst_n;
        o_dmMemRead   = r_dmMemRead;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Directed self-checking bench for load_store_unit. A behavioural data
//   memory (words 1024..2047) is attached to the dm* port. Each request
//   pushes its expected completion into a scoreboard queue; the entry is
//   popped and compared when the DUT raises done.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  memOp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [10:0] dmAddr;
    logic [31:0] dmWriteData;
    logic        dmMemWrite;
    logic        dmMemRead;
    logic [31:0] dmReadData;

    logic [31:0] mem [0:1023];
    logic        preloadEn = 1'b0;
    logic [9:0]  preloadIdx = 10'd0;
    logic [31:0] preloadData = 32'h0;

    int writeCount = 0;
    int readCount  = 0;
    int doneCount  = 0;
    int checks     = 0;
    int failures   = 0;
    int w0;
    int r0;

    typedef struct {
        string       tag;
        logic        expErr;
        logic [31:0] expRdata;
        int          expLat;
        int          expWrites;
        int          expReads;
    } expected_t;

    expected_t sb[$];

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_memOp       (memOp),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_rdata       (rdata),
        .o_dmAddr      (dmAddr),
        .o_dmWriteData (dmWriteData),
        .o_dmMemWrite  (dmMemWrite),
        .o_dmMemRead   (dmMemRead),
        .i_dmReadData  (dmReadData)
    );

    // Combinational read port, gated by the read enable.
    assign dmReadData = dmMemRead ? mem[dmAddr[9:0]] : 32'h0000_0000;

    // Memory write port plus strobe/done counters.
    always @(posedge clk) begin
        if (preloadEn) mem[preloadIdx] <= preloadData;
        if (dmMemWrite) begin
            mem[dmAddr[9:0]] <= dmWriteData;
            writeCount <= writeCount + 1;
        end
        if (dmMemRead) readCount <= readCount + 1;
        if (done) doneCount <= doneCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        preloadIdx  = idx;
        preloadData = data;
        preloadEn   = 1'b1;
        @(negedge clk);
        preloadEn   = 1'b0;
    endtask

    // Push the expectation, then present one request; on return the bench
    // sits at the falling edge of the first cycle after acceptance.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic expErr, input logic [31:0] expRd,
                                 input int expLat, input int expW, input int expR, input bit hold);
        expected_t e;
        e.tag = tag; e.expErr = expErr; e.expRdata = expRd;
        e.expLat = expLat; e.expWrites = expW; e.expReads = expR;
        sb.push_back(e);
        @(negedge clk);
        w0 = writeCount;
        r0 = readCount;
        req = 1'b1; memOp = op; addr = a; wdata = wd;
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare.
    task automatic checkOutput(input bit settle);
        expected_t e;
        int  k;
        bit  seen;
        k = 1;
        seen = 1'b0;
        while (k <= 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({e.tag, "_latency"}, k, e.expLat);
            check({e.tag, "_err"}, {31'd0, err}, {31'd0, e.expErr});
            check({e.tag, "_rdata"}, rdata, e.expRdata);
            check({e.tag, "_writes"}, writeCount - w0, e.expWrites);
            check({e.tag, "_reads"}, readCount - r0, e.expReads);
        end
        if (settle) begin
            @(negedge clk);
            check({e.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({e.tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int d0;
        expected_t e;
        rst_n = 1'b0;
        req   = 1'b0;
        memOp = 3'd0;
        addr  = 32'h0;
        wdata = 32'h0;

        // Reset with memory preload
        preload(10'd0,    32'h8081_7F01);
        preload(10'd1,    32'h1122_3344);
        preload(10'd6,    32'hCAFE_F00D);
        preload(10'd1023, 32'h0000_0000);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_err",    {31'd0, err}, 32'd0);
        check("reset_rd",     {31'd0, dmMemRead}, 32'd0);
        check("reset_wr",     {31'd0, dmMemWrite}, 32'd0);
        check("reset_rdata",  rdata, 32'd0);
        check("reset_dmaddr", {21'd0, dmAddr}, 32'd0);
        check("reset_dmwd",   dmWriteData, 32'd0);
        check("reset_nowrite", writeCount, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sub-word loads from word 1024 = 8081_7F01
        applyStimulus("lb",  3'd3, 32'h0000_1000, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 1, 1'b0);
        checkOutput(1'b1);
        applyStimulus("lbu", 3'd4, 32'h0000_1000, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 1, 1'b0);
        checkOutput(1'b1);
        applyStimulus("lh",  3'd1, 32'h0000_1002, 32'h0, 1'b0, 32'h0000_7F01, 2, 0, 1, 1'b0);
        checkOutput(1'b1);
        applyStimulus("lhu", 3'd2, 32'h0000_1000, 32'h0, 1'b0, 32'h0000_8081, 2, 0, 1, 1'b0);
        checkOutput(1'b1);

        // SB read-modify-write into word 1025, then read back
        applyStimulus("sb", 3'd7, 32'h0000_1005, 32'h0000_00AA, 1'b0, 32'h0000_8081, 3, 1, 1, 1'b0);
        checkOutput(1'b1);
        check("sb_mem", mem[1], 32'h11AA_3344);
        check("sb_dmwd", dmWriteData, 32'h11AA_3344);
        applyStimulus("lw_after_sb", 3'd0, 32'h0000_1004, 32'h0, 1'b0, 32'h11AA_3344, 2, 0, 1, 1'b0);
        checkOutput(1'b1);

        // Illegal addresses: immediate err completion, no strobes, rdata held
        applyStimulus("err_lw_mis",   3'd0, 32'h0000_1002, 32'h0, 1'b1, 32'h11AA_3344, 1, 0, 0, 1'b0);
        checkOutput(1'b1);
        applyStimulus("err_sh_mis",   3'd6, 32'h0000_1001, 32'h5555, 1'b1, 32'h11AA_3344, 1, 0, 0, 1'b0);
        checkOutput(1'b1);
        applyStimulus("err_lw_below", 3'd0, 32'h0000_0FFC, 32'h0, 1'b1, 32'h11AA_3344, 1, 0, 0, 1'b0);
        checkOutput(1'b1);
        applyStimulus("err_sw_above", 3'd5, 32'h0000_2000, 32'h1234_5678, 1'b1, 32'h11AA_3344, 1, 0, 0, 1'b0);
        checkOutput(1'b1);
        check("err_mem_intact", mem[1], 32'h11AA_3344);

        // SW with req held high, then a second request at the first free edge
        applyStimulus("sw_hold", 3'd5, 32'h0000_1FFC, 32'hDEAD_BEEF, 1'b0, 32'h11AA_3344, 2, 1, 0, 1'b1);
        checkOutput(1'b0);
        e.tag = "lw_b2b"; e.expErr = 1'b0; e.expRdata = 32'hDEAD_BEEF;
        e.expLat = 2; e.expWrites = 0; e.expReads = 1;
        sb.push_back(e);
        w0 = writeCount;
        r0 = readCount;
        memOp = 3'd0; addr = 32'h0000_1FFC; wdata = 32'h0;
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_read", {31'd0, dmMemRead}, 32'd1);
        req = 1'b0;
        checkOutput(1'b1);
        check("sw_hold_mem", mem[1023], 32'hDEAD_BEEF);

        // Reset during MERGE_WR of an SH: no write, no done, back to IDLE
        d0 = doneCount;
        @(negedge clk);
        w0 = writeCount;
        req = 1'b1; memOp = 3'd6; addr = 32'h0000_1018; wdata = 32'h0000_1234;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_mid_in_merge", {31'd0, dmMemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_gated", {31'd0, dmMemWrite}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_writes", writeCount - w0, 32'd0);
        check("rst_mid_mem", mem[6], 32'hCAFE_F00D);
        check("rst_mid_done", doneCount - d0, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        applyStimulus("lw_after_rst", 3'd0, 32'h0000_1018, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 1, 1'b0);
        checkOutput(1'b1);

        // SH lower half into the same word
        applyStimulus("sh_low", 3'd6, 32'h0000_101A, 32'h0000_BEEF, 1'b0, 32'hCAFE_F00D, 3, 1, 1, 1'b0);
        checkOutput(1'b1);
        check("sh_low_mem", mem[6], 32'hCAFE_BEEF);

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
